// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 4-digit 7-segment driver for a packed BCD value.
// Snapshots on load, scans at SCAN_DIV cycles per digit, blanks leading zeros.
module bcd_display_scanner #(
    parameter int unsigned SCAN_DIV = 4,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd_in,
    input  logic        load,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        DIG0,
        DIG1,
        DIG2,
        DIG3
    } digit_e;

    digit_e            idx;
    digit_e            idx_next;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_next;
    logic [15:0]       snap;
    logic              dwell_end;

    logic [3:0]        nib;
    logic              blank;
    logic              lz3;
    logic              lz2;
    logic              lz1;
    logic [3:0]        an_next;
    logic [6:0]        seg_next;
    logic              frame_next;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h79;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap <= '0;
        end else if (load) begin
            snap <= bcd_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx     <= DIG0;
            div_cnt <= '0;
        end else begin
            idx     <= idx_next;
            div_cnt <= div_next;
        end
    end

    assign dwell_end = (div_cnt == DIV_LAST);

    always_comb begin
        idx_next = idx;
        div_next = div_cnt + DIV_W'(1);
        if (dwell_end) begin
            div_next = '0;
            case (idx)
                DIG0:    idx_next = DIG1;
                DIG1:    idx_next = DIG2;
                DIG2:    idx_next = DIG3;
                default: idx_next = DIG0;
            endcase
        end
    end

    // A digit is a leading zero only if it and every more-significant digit are 0.
    assign lz3 = (snap[15:12] == 4'd0);
    assign lz2 = lz3 && (snap[11:8] == 4'd0);
    assign lz1 = lz2 && (snap[7:4] == 4'd0);

    always_comb begin
        nib     = snap[3:0];
        blank   = 1'b0;
        an_next = 4'b0001;
        case (idx)
            DIG0: begin
                nib     = snap[3:0];
                an_next = 4'b0001;
            end
            DIG1: begin
                nib     = snap[7:4];
                blank   = BLANK_LZ && lz1;
                an_next = 4'b0010;
            end
            DIG2: begin
                nib     = snap[11:8];
                blank   = BLANK_LZ && lz2;
                an_next = 4'b0100;
            end
            default: begin
                nib     = snap[15:12];
                blank   = BLANK_LZ && lz3;
                an_next = 4'b1000;
            end
        endcase
        seg_next   = blank ? 7'h00 : decode(nib);
        frame_next = dwell_end && (idx == DIG3);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= 4'b0001;
            seg        <= 7'h3F;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            frame_done <= frame_next;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: arithmetic reference model checked every cycle,
// plus directed literal expectations; three instances cover both blanking modes and SCAN_DIV=1.
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] bcd_in = '0;
    logic        load = 1'b0;

    logic [6:0] seg_a, seg_b, seg_c;
    logic [3:0] an_a, an_b, an_c;
    logic       fd_a, fd_b, fd_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bcd_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bcd_in(bcd_in), .load(load),
        .seg(seg_a), .an(an_a), .frame_done(fd_a)
    );
    bcd_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bcd_in(bcd_in), .load(load),
        .seg(seg_b), .an(an_b), .frame_done(fd_b)
    );
    bcd_display_scanner #(.SCAN_DIV(1), .BLANK_LZ(1'b1)) dut_c (
        .clk(clk), .reset(reset), .bcd_in(bcd_in), .load(load),
        .seg(seg_c), .an(an_c), .frame_done(fd_c)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h79;
        endcase
    endfunction

    // Output after the next edge, given k edges since reset and the current snapshot.
    function automatic logic [11:0] model_out(input int unsigned k, input logic [15:0] s,
                                              input int unsigned d, input bit blank_lz);
        int unsigned i;
        logic [3:0]  n;
        logic [6:0]  sg;
        logic [3:0]  a;
        logic        fd;
        i  = (k / d) % 4;
        n  = 4'(s >> (4 * i));
        sg = seg_of(n);
        if (blank_lz && i != 0 && (s >> (4 * i)) == 16'd0) sg = 7'h00;
        a  = 4'(1 << i);
        fd = ((k + 1) % (4 * d)) == 0;
        return {fd, a, sg};
    endfunction

    localparam logic [11:0] RST_OUT = {1'b0, 4'b0001, 7'h3F};

    int unsigned k;
    logic [15:0] msnap;
    logic [11:0] exp_a, exp_b, exp_c;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k     = 0;
            msnap = '0;
            exp_a = RST_OUT;
            exp_b = RST_OUT;
            exp_c = RST_OUT;
        end else begin
            exp_a = model_out(k, msnap, 4, 1'b1);
            exp_b = model_out(k, msnap, 4, 1'b0);
            exp_c = model_out(k, msnap, 1, 1'b1);
            k = k + 1;
            if (load) msnap = bcd_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_a", {20'd0, fd_a, an_a, seg_a}, {20'd0, exp_a});
        chk("model_b", {20'd0, fd_b, an_b, seg_b}, {20'd0, exp_b});
        chk("model_c", {20'd0, fd_c, an_c, seg_c}, {20'd0, exp_c});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic digit_seg(input int i, output logic [6:0] sa, output logic [6:0] sb);
        bit found = 1'b0;
        sa = 'x;
        sb = 'x;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (an_a == 4'(1 << i)) begin
                sa    = seg_a;
                sb    = seg_b;
                found = 1'b1;
            end
        end
        chk("digit_wait", {31'd0, found}, 32'd1);
    endtask

    task automatic load_value(input logic [15:0] v);
        bcd_in = v;
        load   = 1'b1;
        tick(1);
        load   = 1'b0;
        tick(17);
    endtask

    task automatic wait_phase(input int unsigned ph);
        bit found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (k % 16 == ph) found = 1'b1;
            else @(negedge clk);
        end
        chk("phase_wait", {31'd0, found}, 32'd1);
    endtask

    logic [6:0] sa, sb;

    initial begin
        tick(2);
        chk("rst_an", an_a, 4'b0001);
        chk("rst_seg", seg_a, 7'h3F);
        chk("rst_fd", fd_a, 1'b0);

        // Idle scan of zero.
        reset = 1'b0;
        tick(4);
        chk("c_fd_4", fd_c, 1'b1);
        tick(1);
        chk("an_5", an_a, 4'b0010);
        chk("seg_5_blank", seg_a, 7'h00);
        chk("c_an_5", an_c, 4'b0001);
        tick(11);
        chk("fd_16", fd_a, 1'b1);
        chk("an_16", an_a, 4'b1000);
        chk("seg_16", seg_a, 7'h00);
        tick(1);
        chk("an_17", an_a, 4'b0001);
        chk("seg_17", seg_a, 7'h3F);
        chk("fd_17", fd_a, 1'b0);

        // Snapshot ignores bcd_in once load drops.
        bcd_in = 16'h1234;
        load   = 1'b1;
        tick(1);
        load   = 1'b0;
        bcd_in = 16'h9999;
        tick(17);
        digit_seg(0, sa, sb); chk("1234_d0", sa, 7'h66);
        digit_seg(1, sa, sb); chk("1234_d1", sa, 7'h4F);
        digit_seg(2, sa, sb); chk("1234_d2", sa, 7'h5B);
        digit_seg(3, sa, sb); chk("1234_d3", sa, 7'h06);

        load_value(16'h0070);
        digit_seg(0, sa, sb); chk("0070_d0", sa, 7'h3F);
        digit_seg(1, sa, sb); chk("0070_d1", sa, 7'h07);
        digit_seg(2, sa, sb); chk("0070_d2", sa, 7'h00); chk("0070_d2_nolz", sb, 7'h3F);
        digit_seg(3, sa, sb); chk("0070_d3", sa, 7'h00); chk("0070_d3_nolz", sb, 7'h3F);

        load_value(16'h00A5);
        digit_seg(0, sa, sb); chk("00A5_d0", sa, 7'h6D);
        digit_seg(1, sa, sb); chk("00A5_d1", sa, 7'h79);
        digit_seg(2, sa, sb); chk("00A5_d2", sa, 7'h00);
        digit_seg(3, sa, sb); chk("00A5_d3", sa, 7'h00);

        // Load coinciding with the 3->0 wrap.
        wait_phase(15);
        bcd_in = 16'h0008;
        load   = 1'b1;
        tick(1);
        load   = 1'b0;
        chk("wrap_fd", fd_a, 1'b1);
        chk("wrap_an_prev", an_a, 4'b1000);
        tick(1);
        chk("wrap_an", an_a, 4'b0001);
        chk("wrap_seg", seg_a, 7'h7F);
        chk("wrap_fd_off", fd_a, 1'b0);

        // Asynchronous reset while idx=2, between clock edges.
        wait_phase(9);
        #2 reset = 1'b1;
        #1;
        chk("async_an", an_a, 4'b0001);
        chk("async_seg", seg_a, 7'h3F);
        chk("async_fd", fd_a, 1'b0);
        chk("async_an_c", an_c, 4'b0001);
        tick(2);
        reset = 1'b0;
        tick(4);
        chk("restart_an_4", an_a, 4'b0001);
        chk("restart_seg_4", seg_a, 7'h3F);
        tick(1);
        chk("restart_an_5", an_a, 4'b0010);

        tick(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
